mem_1w1r: RTL and testbench
===========================

Name: mem_1w1r

Overview:
- Parameterised synchronous RAM with one independent write port and one independent read port.
- Readdata is registered and holds its value between reads.
- Used as the tag, physical-tag and access-tag storage in the TLB way; one instance per field per way.
- Infers block/distributed RAM; no handshake, and both ports may be active in the same cycle.

Parameters:
- ELEMENTS_W, default 4: address width; depth = 2**ELEMENTS_W entries.
- WIDTH, default 8: data width of each entry in bits.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset; synchronous, active-low; clock clk.
- read  input  1  read enable, sampled at posedge clk.
- readaddress  input  ELEMENTS_W  entry to read.
- readdata  output  WIDTH  registered read result.
- write  input  1  write enable, sampled at posedge clk.
- writeaddress  input  ELEMENTS_W  entry to write.
- writedata  input  WIDTH  data to store.

Behaviour:
- Storage: array of 2**ELEMENTS_W words of WIDTH bits.
  - Contents are not initialised and not cleared by reset.
  - The bench must write an entry before checking a read from it.
- Write:
  - At posedge clk with rst_n=1 and write=1: mem[writeaddress] <= writedata.
  - The new value is visible to reads issued from the next cycle onward.
- Read:
  - At posedge clk with rst_n=1 and read=1: readdata <= mem[readaddress].
  - Latency is exactly 1 cycle: the address is presented in cycle N and the data is valid after edge N, i.e. during cycle N+1.
- Hold: when read=0, readdata keeps its last value indefinitely. Intervening writes, including writes to the last-read address, do not change it.
- Simultaneous read and write to different addresses: both complete independently in the same cycle.
- Simultaneous read and write to the same address: read-first.
  - readdata returns the old contents.
  - The array holds writedata afterwards.
  - A read of that address in the next cycle returns writedata.
- Reset:
  - At posedge clk with rst_n=0, readdata <= 0.
  - Read and write enables are ignored during reset.
  - Memory contents are preserved across reset.
  - Reset asserted mid-sequence (between a read request and its use) clears readdata to 0.
- Addressing: addresses are exactly ELEMENTS_W bits wide, so no out-of-range access exists. Address 0 and address 2**ELEMENTS_W-1 are both ordinary entries with no wrap.
- Simulation checks (non-synthesised):
  - Flag an error if write=1 while writeaddress or writedata contains X/Z.
  - Flag an error if read=1 while readaddress contains X/Z.
  - Neither check changes RTL behaviour.
- No combinational path from any input to readdata.

Decomposition:
- No shared package needed; the block is fully parameterised and standalone.
- No sub-modules. A single always block holds the array write and the registered read, so the array maps onto inferred RAM.

Test Plan:
- Reset and hold: hold rst_n=0 for 2 cycles with read=1 -> readdata=0. Release rst_n with read=0 -> readdata stays 0.
- Basic write/read (WIDTH=8, ELEMENTS_W=4):
  - Write 0xA5 to addr 3, then read addr 3 -> readdata=0xA5 one cycle after the read request.
  - Read addr 15 after writing 0x3C there -> 0x3C.
- Hold: read addr 3 (0xA5), deassert read, then write 0x11 to addr 3 and 0x22 to addr 4 -> readdata remains 0xA5 until the next read, which returns 0x11.
- Same-cycle different addresses:
  - Setup: addr 5=0x55, addr 6=0x66.
  - Stimulus: read addr 5 while writing 0x77 to addr 6 -> readdata=0x55. Subsequent read of addr 6 -> 0x77.
- Read-first collision: with addr 7=0x10, read and write addr 7 with 0x20 in the same cycle -> readdata=0x10; next-cycle read of addr 7 -> 0x20.
- Back-to-back and reset persistence:
  - Fill all 16 entries with data = address XOR 0xF0.
  - Read addresses 0..15 on consecutive cycles -> each value appears exactly one cycle after its address.
  - Pulse rst_n low for 1 cycle -> readdata=0.
  - Re-read addr 9 -> 0xF9 (contents preserved).

Source files
------------

// File: rtl/mem_1w1r.sv
// mem_1w1r: 1-write/1-read synchronous RAM with registered, read-first readdata.
// Contents are not cleared by reset; only the read register is.
module mem_1w1r #(
   parameter int ELEMENTS_W = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  read,
   input  logic [ELEMENTS_W-1:0] readaddress,
   output logic [WIDTH-1:0]      readdata,
   input  logic                  write,
   input  logic [ELEMENTS_W-1:0] writeaddress,
   input  logic [WIDTH-1:0]      writedata
);
   logic [WIDTH-1:0] mem_q [2**ELEMENTS_W];
   logic [WIDTH-1:0] readdata_q;
   // One block for array and read register keeps RAM inference; NBA gives read-first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         readdata_q <= '0;
      end else begin
         if (write) mem_q[writeaddress] <= writedata;
         if (read) readdata_q <= mem_q[readaddress];
      end
   end
   assign readdata = readdata_q;
`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && write) assert (!$isunknown({writeaddress, writedata}))
         else $error("mem_1w1r: write with X/Z address or data");
      if (rst_n && read) assert (!$isunknown(readaddress))
         else $error("mem_1w1r: read with X/Z address");
   end
`endif
endmodule

// File: tb/tb_mem_1w1r.sv
// tb_mem_1w1r: scoreboard bench for mem_1w1r; an array reference model predicts
// readdata after every edge and a negedge monitor compares it.
module tb_mem_1w1r;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          read;
   logic [AW-1:0] readaddress;
   logic [DW-1:0] readdata;
   logic          write;
   logic [AW-1:0] writeaddress;
   logic [DW-1:0] writedata;

   mem_1w1r #(.ELEMENTS_W(AW), .WIDTH(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .read(read),
      .readaddress(readaddress),
      .readdata(readdata),
      .write(write),
      .writeaddress(writeaddress),
      .writedata(writedata)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ref_mem [DEPTH];
   bit            ref_ok  [DEPTH];
   logic [DW-1:0] ref_last = '0;
   logic [DW-1:0] exp_q [$];
   string         name_q [$];
   int            checks = 0;
   int            errors = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [DW-1:0] e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checks++;
         if (readdata !== e) begin
            errors++;
            $display("FAIL %s: readdata=%h expected %h at %0t", n, readdata, e, $time);
         end
      end
   end

   // Drive one cycle; the model predicts readdata after the edge (read sees pre-write contents).
   task automatic step(input bit rn, input bit rd, input logic [AW-1:0] ra,
                       input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input string n);
      logic [DW-1:0] e;
      rst_n = rn; read = rd; readaddress = ra;
      write = wr; writeaddress = wa; writedata = wd;
      e = ref_last;
      if (!rn) e = '0;
      else if (rd) begin
         if (!ref_ok[ra]) $display("bench note: read of unwritten entry %0d", ra);
         e = ref_mem[ra];
      end
      if (rn && wr) begin
         ref_mem[wa] = wd;
         ref_ok[wa] = 1'b1;
      end
      ref_last = e;
      @(posedge clk);
      exp_q.push_back(e);
      name_q.push_back(n);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_ok[i] = 1'b0;
      step(0, 1, 0, 1, 0, 8'hEE, "reset_read_ignored");
      step(0, 1, 0, 1, 1, 8'hEE, "reset_read_ignored");
      step(1, 0, 0, 0, 0, 8'h00, "post_reset_hold");
      step(1, 0, 0, 1, 3, 8'hA5, "post_reset_hold");
      step(1, 1, 3, 0, 0, 8'h00, "basic_read_a5");
      step(1, 0, 0, 1, 15, 8'h3C, "basic_hold");
      step(1, 1, 15, 0, 0, 8'h00, "read_top_addr");
      step(1, 1, 3, 0, 0, 8'h00, "hold_setup_read");
      step(1, 0, 0, 1, 3, 8'h11, "hold_write_same");
      step(1, 0, 0, 1, 4, 8'h22, "hold_write_other");
      step(1, 0, 0, 0, 0, 8'h00, "hold_idle");
      step(1, 1, 3, 0, 0, 8'h00, "hold_reread_11");
      step(1, 0, 0, 1, 5, 8'h55, "diff_setup");
      step(1, 0, 0, 1, 6, 8'h66, "diff_setup");
      step(1, 1, 5, 1, 6, 8'h77, "diff_read_55");
      step(1, 1, 6, 0, 0, 8'h00, "diff_read_77");
      step(1, 0, 0, 1, 7, 8'h10, "collide_setup");
      step(1, 1, 7, 1, 7, 8'h20, "collide_old_10");
      step(1, 1, 7, 0, 0, 8'h00, "collide_new_20");
      for (int i = 0; i < DEPTH; i++)
         step(1, 0, 0, 1, AW'(i), DW'(i) ^ 8'hF0, "fill_hold");
      for (int i = 0; i < DEPTH; i++)
         step(1, 1, AW'(i), 0, 0, 8'h00, "b2b_read");
      step(0, 1, 2, 1, 9, 8'h99, "reset_clears");
      step(1, 0, 0, 0, 0, 8'h00, "reset_after_hold");
      step(1, 1, 9, 0, 0, 8'h00, "persist_f9");
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1,
              AW'($urandom), $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), "random");
      read = 1'b0; write = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d pending expectations, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
